// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two master request/response channels and the
// memory data-port pins used by mem_arbiter. The slave modport is the arbiter's
// view; the master modport is the view of whatever drives the requests and
// models the memory.
interface mem_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [2:0]  m0_write_enable;
  logic [31:0] m0_data_in;
  logic        m0_ack;
  logic [31:0] m0_data_out;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [2:0]  m1_write_enable;
  logic [31:0] m1_data_in;
  logic        m1_ack;
  logic [31:0] m1_data_out;

  logic [31:0] mem_addr;
  logic [2:0]  mem_write_enable;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  logic [1:0]  grant;
  logic        busy;

  modport slave (
    input  m0_req, m0_addr, m0_write_enable, m0_data_in,
    output m0_ack, m0_data_out,
    input  m1_req, m1_addr, m1_write_enable, m1_data_in,
    output m1_ack, m1_data_out,
    output mem_addr, mem_write_enable, mem_data_in,
    input  mem_data_out,
    output grant, busy
  );

  modport master (
    output m0_req, m0_addr, m0_write_enable, m0_data_in,
    input  m0_ack, m0_data_out,
    output m1_req, m1_addr, m1_write_enable, m1_data_in,
    input  m1_ack, m1_data_out,
    input  mem_addr, mem_write_enable, mem_data_in,
    output mem_data_out,
    input  grant, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single data port of memory between master 0 (CPU
// load/store unit) and master 1 (DMA / debug). Each request is latched,
// driven onto the memory port for one ACCESS cycle, and answered with a
// one-cycle ack carrying the read data (RESP).
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to break ties in favour of the
// master that did not win last; otherwise master 0 always wins ties.
module mem_arbiter (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  grant_r;
  logic        busy_r;
  logic        m0_ack_r;
  logic        m1_ack_r;
  logic [31:0] m0_data_out_r;
  logic [31:0] m1_data_out_r;
  logic [31:0] mem_addr_r;
  logic [2:0]  mem_write_enable_r;
  logic [31:0] mem_data_in_r;

  // Winner of the current IDLE cycle: 1'b0 = master 0, 1'b1 = master 1.
  logic        win_s;
  logic        req_any_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Winner of the most recent IDLE->ACCESS transition.
  logic        last_grant_r;
`endif

  assign req_any_s = bus.m0_req | bus.m1_req;

  // Pick the winner among the current requesters.
  always_comb begin
    win_s = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win_s = ~last_grant_r;
`else
      win_s = 1'b0;
`endif
    end else if (bus.m1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember who won the last grant; reset favours master 0 on the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (state_r == IDLE && req_any_s) begin
      last_grant_r <= win_s;
    end
  end
`endif

  // Transaction FSM: latch request, drive memory for one cycle, pulse ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r            <= IDLE;
      grant_r            <= 2'b00;
      busy_r             <= 1'b0;
      m0_ack_r           <= 1'b0;
      m1_ack_r           <= 1'b0;
      m0_data_out_r      <= 32'h0000_0000;
      m1_data_out_r      <= 32'h0000_0000;
      mem_addr_r         <= 32'h0000_0000;
      mem_write_enable_r <= 3'b000;
      mem_data_in_r      <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_any_s) begin
            if (win_s) begin
              mem_addr_r         <= bus.m1_addr;
              mem_write_enable_r <= bus.m1_write_enable;
              mem_data_in_r      <= bus.m1_data_in;
              grant_r            <= 2'b10;
            end else begin
              mem_addr_r         <= bus.m0_addr;
              mem_write_enable_r <= bus.m0_write_enable;
              mem_data_in_r      <= bus.m0_data_in;
              grant_r            <= 2'b01;
            end
            busy_r  <= 1'b1;
            state_r <= ACCESS;
          end
        end
        ACCESS: begin
          // Memory read data is combinational from mem_addr; capture it now.
          mem_write_enable_r <= 3'b000;
          if (grant_r[1]) begin
            m1_data_out_r <= bus.mem_data_out;
            m1_ack_r      <= 1'b1;
          end else begin
            m0_data_out_r <= bus.mem_data_out;
            m0_ack_r      <= 1'b1;
          end
          state_r <= RESP;
        end
        RESP: begin
          // Requests are deliberately ignored here so a held req is not
          // re-granted during its own ack cycle.
          m0_ack_r <= 1'b0;
          m1_ack_r <= 1'b0;
          grant_r  <= 2'b00;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          mem_write_enable_r <= 3'b000;
          m0_ack_r           <= 1'b0;
          m1_ack_r           <= 1'b0;
          grant_r            <= 2'b00;
          busy_r             <= 1'b0;
          state_r            <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant            = grant_r;
  assign bus.busy             = busy_r;
  assign bus.m0_ack           = m0_ack_r;
  assign bus.m1_ack           = m1_ack_r;
  assign bus.m0_data_out      = m0_data_out_r;
  assign bus.m1_data_out      = m1_data_out_r;
  assign bus.mem_addr         = mem_addr_r;
  assign bus.mem_write_enable = mem_write_enable_r;
  assign bus.mem_data_in      = mem_data_in_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small word-addressed
// memory model (combinational read, write committed on the clock edge).
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 16 words selected by address bits [5:2].
  logic [31:0] mem [0:15];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_data;

  assign bus.mem_data_out = mem[bus.mem_addr[5:2]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (bus.mem_write_enable[0]) begin
      mem[bus.mem_addr[5:2]] <= bus.mem_data_in;
    end else if (bus.mem_write_enable[1]) begin
      if (bus.mem_addr[1]) mem[bus.mem_addr[5:2]][31:16] <= bus.mem_data_in[15:0];
      else                 mem[bus.mem_addr[5:2]][15:0]  <= bus.mem_data_in[15:0];
    end else if (bus.mem_write_enable[2]) begin
      case (bus.mem_addr[1:0])
        2'd0: mem[bus.mem_addr[5:2]][7:0]   <= bus.mem_data_in[7:0];
        2'd1: mem[bus.mem_addr[5:2]][15:8]  <= bus.mem_data_in[7:0];
        2'd2: mem[bus.mem_addr[5:2]][23:16] <= bus.mem_data_in[7:0];
        default: mem[bus.mem_addr[5:2]][31:24] <= bus.mem_data_in[7:0];
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] d);
    pl_en = 1'b1; pl_idx = idx; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic drive_m0(input logic r, input logic [31:0] a, input logic [2:0] we, input logic [31:0] d);
    bus.m0_req = r; bus.m0_addr = a; bus.m0_write_enable = we; bus.m0_data_in = d;
  endtask

  task automatic drive_m1(input logic r, input logic [31:0] a, input logic [2:0] we, input logic [31:0] d);
    bus.m1_req = r; bus.m1_addr = a; bus.m1_write_enable = we; bus.m1_data_in = d;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.grant !== 2'b00) begin n_err++; $display("FAIL reset_grant got %h want 0", bus.grant); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if ({bus.m0_ack, bus.m1_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks got %b want 00", {bus.m0_ack, bus.m1_ack}); end
    n_cmp++; if ({bus.m0_data_out, bus.m1_data_out} !== 64'h0) begin n_err++; $display("FAIL reset_data_out got %h want 0", {bus.m0_data_out, bus.m1_data_out}); end
    n_cmp++; if ({bus.mem_addr, bus.mem_write_enable, bus.mem_data_in} !== 67'h0) begin n_err++; $display("FAIL reset_mem_port got %h %h %h want 0", bus.mem_addr, bus.mem_write_enable, bus.mem_data_in); end
  endtask

  task automatic test_single_read();
    drive_m0(1'b1, 32'h1000_0004, 3'b000, 32'h0);
    tick(); // ACCESS
    n_cmp++; if (bus.grant !== 2'b01 || bus.busy !== 1'b1) begin n_err++; $display("FAIL read_access grant=%h busy=%b want 01/1", bus.grant, bus.busy); end
    n_cmp++; if (bus.mem_write_enable !== 3'b000 || bus.m0_ack !== 1'b0) begin n_err++; $display("FAIL read_access_we we=%h ack=%b want 0/0", bus.mem_write_enable, bus.m0_ack); end
    tick(); // RESP
    n_cmp++; if (bus.m0_ack !== 1'b1 || bus.m0_data_out !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL read_resp ack=%b data=%h want 1/deadbeef", bus.m0_ack, bus.m0_data_out); end
    n_cmp++; if (bus.m1_ack !== 1'b0 || bus.mem_write_enable !== 3'b000) begin n_err++; $display("FAIL read_resp_other m1_ack=%b we=%h want 0/0", bus.m1_ack, bus.mem_write_enable); end
    drive_m0(1'b0, 32'h1000_0004, 3'b000, 32'h0);
    tick(); // IDLE
    n_cmp++; if (bus.m0_ack !== 1'b0 || bus.grant !== 2'b00 || bus.busy !== 1'b0) begin n_err++; $display("FAIL read_idle ack=%b grant=%h busy=%b want 0/0/0", bus.m0_ack, bus.grant, bus.busy); end
    n_cmp++; if (bus.m0_data_out !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL read_hold data=%h want deadbeef", bus.m0_data_out); end
  endtask

  task automatic test_write_then_read();
    int we_cycles;
    we_cycles = 0;
    drive_m1(1'b1, 32'h1000_0010, 3'b001, 32'hA5A5_A5A5);
    tick(); // ACCESS
    if (bus.mem_write_enable === 3'b001) we_cycles++;
    n_cmp++; if (bus.grant !== 2'b10 || bus.mem_addr !== 32'h1000_0010 || bus.mem_data_in !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL write_access grant=%h addr=%h din=%h want 10/10000010/a5a5a5a5", bus.grant, bus.mem_addr, bus.mem_data_in); end
    tick(); // RESP
    if (bus.mem_write_enable === 3'b001) we_cycles++;
    n_cmp++; if (bus.m1_ack !== 1'b1 || bus.m0_ack !== 1'b0) begin n_err++; $display("FAIL write_ack m1=%b m0=%b want 1/0", bus.m1_ack, bus.m0_ack); end
    drive_m1(1'b0, 32'h0, 3'b000, 32'h0);
    drive_m0(1'b1, 32'h1000_0010, 3'b000, 32'h0);
    tick(); // IDLE
    if (bus.mem_write_enable === 3'b001) we_cycles++;
    tick(); // ACCESS (m0 read)
    if (bus.mem_write_enable === 3'b001) we_cycles++;
    tick(); // RESP
    n_cmp++; if (we_cycles != 1) begin n_err++; $display("FAIL write_we_cycles got %0d want 1", we_cycles); end
    n_cmp++; if (bus.m0_ack !== 1'b1 || bus.m0_data_out !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL write_readback ack=%b data=%h want 1/a5a5a5a5", bus.m0_ack, bus.m0_data_out); end
    drive_m0(1'b0, 32'h0, 3'b000, 32'h0);
    tick(); // IDLE
  endtask

  task automatic test_continuous_tie();
    logic [1:0] exp_g;
    rst = 1'b1; #2; rst = 1'b0; // fresh arbitration history
    drive_m0(1'b1, 32'h1000_0004, 3'b000, 32'h0);
    drive_m1(1'b1, 32'h1000_0010, 3'b000, 32'h0);
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      tick(); // ACCESS
      n_cmp++; if (bus.grant !== exp_g) begin n_err++; $display("FAIL tie_grant[%0d] got %h want %h", t, bus.grant, exp_g); end
      tick(); // RESP
      n_cmp++; if ({bus.m1_ack, bus.m0_ack} !== exp_g) begin n_err++; $display("FAIL tie_ack[%0d] got %b want %b", t, {bus.m1_ack, bus.m0_ack}, exp_g); end
      tick(); // IDLE
    end
    drive_m0(1'b0, 32'h0, 3'b000, 32'h0);
    drive_m1(1'b0, 32'h0, 3'b000, 32'h0);
    tick();
  endtask

  task automatic test_back_to_back();
    int  acks;
    int  dbl;
    logic prev;
    acks = 0; dbl = 0; prev = 1'b0;
    drive_m0(1'b1, 32'h1000_0004, 3'b000, 32'h0);
    for (int c = 0; c < 9; c++) begin
      tick();
      if (bus.m0_ack === 1'b1) acks++;
      if (bus.m0_ack === 1'b1 && prev) dbl++;
      prev = bus.m0_ack;
      if (c == 7) drive_m0(1'b0, 32'h0, 3'b000, 32'h0);
    end
    n_cmp++; if (acks != 3) begin n_err++; $display("FAIL held_req_acks got %0d want 3", acks); end
    n_cmp++; if (dbl != 0) begin n_err++; $display("FAIL held_req_double got %0d want 0", dbl); end
  endtask

  task automatic test_byte_write();
    drive_m0(1'b1, 32'h1000_0001, 3'b100, 32'h0000_0042);
    tick(); // ACCESS
    n_cmp++; if (bus.mem_addr !== 32'h1000_0001 || bus.mem_data_in !== 32'h0000_0042 || bus.mem_write_enable !== 3'b100) begin n_err++; $display("FAIL byte_access addr=%h din=%h we=%h want 10000001/42/4", bus.mem_addr, bus.mem_data_in, bus.mem_write_enable); end
    tick(); // RESP
    drive_m0(1'b1, 32'h1000_0000, 3'b000, 32'h0);
    tick(); // IDLE
    tick(); // ACCESS
    tick(); // RESP
    n_cmp++; if (bus.m0_ack !== 1'b1 || bus.m0_data_out !== 32'h1122_4244) begin n_err++; $display("FAIL byte_readback ack=%b data=%h want 1/11224244", bus.m0_ack, bus.m0_data_out); end
    drive_m0(1'b0, 32'h0, 3'b000, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid_write();
    int late_acks;
    late_acks = 0;
    drive_m0(1'b1, 32'h1000_0020, 3'b001, 32'h1234_5678);
    tick(); // ACCESS
    n_cmp++; if (bus.mem_write_enable !== 3'b001) begin n_err++; $display("FAIL rstw_access we=%h want 1", bus.mem_write_enable); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.mem_write_enable !== 3'b000 || bus.grant !== 2'b00 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rstw_async we=%h grant=%h busy=%b want 0/0/0", bus.mem_write_enable, bus.grant, bus.busy); end
    n_cmp++; if (bus.mem_addr !== 32'h0 || bus.mem_data_in !== 32'h0 || bus.m0_data_out !== 32'h0) begin n_err++; $display("FAIL rstw_regs addr=%h din=%h dout=%h want 0/0/0", bus.mem_addr, bus.mem_data_in, bus.m0_data_out); end
    drive_m0(1'b0, 32'h0, 3'b000, 32'h0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) late_acks++;
    end
    n_cmp++; if (late_acks != 0) begin n_err++; $display("FAIL rstw_no_ack got %0d want 0", late_acks); end
    drive_m0(1'b1, 32'h1000_0020, 3'b000, 32'h0);
    tick(); tick();
    n_cmp++; if (bus.m0_ack !== 1'b1 || bus.m0_data_out !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rstw_readback ack=%b data=%h want 1/cafef00d", bus.m0_ack, bus.m0_data_out); end
    drive_m0(1'b0, 32'h0, 3'b000, 32'h0);
    tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; pl_en = 1'b0; pl_idx = 4'd0; pl_data = 32'h0;
    drive_m0(1'b0, 32'h0, 3'b000, 32'h0);
    drive_m1(1'b0, 32'h0, 3'b000, 32'h0);
    preload(4'd0, 32'h1122_3344);
    preload(4'd1, 32'hDEAD_BEEF);
    preload(4'd4, 32'h0000_0000);
    preload(4'd8, 32'hCAFE_F00D);
    test_reset();
    rst = 1'b0;
    tick();
    test_single_read();
    test_write_then_read();
    test_continuous_tie();
    test_back_to_back();
    test_byte_write();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
